draw_player: RTL and testbench

- Sprite overlay stage directly downstream of draw_menu in the 1024x768 @ 65 MHz video pipeline (1344x806 total timing).
- Consumes draw_menu's vga_if stream and overlays a SPRITE_W x SPRITE_H player sprite, fetched from a synchronous image_rom, at a frame-latched position.
- Applies colour-key transparency and optional horizontal mirroring.
- Delays all timing signals to stay aligned with the ROM read latency.

---
 rtl/draw_player_if.sv | 14 +
 rtl/draw_player.sv | 167 ++++++++++++++++
 tb/tb_draw_player.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/draw_player_if.sv
// VGA stream bundle shared by the drawing stages of the video pipeline.
// The src modport drives the stream and the snk modport consumes it.
interface vga_if;
    logic [10:0] hcount;
    logic [10:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
    logic [11:0] rgb;

    modport src (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
    modport snk (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/draw_player.sv
// Player sprite overlay: the position is latched once per frame, the sprite is read from a
// synchronous ROM, and key-colour pixels are transparent. Every field has a fixed 3-clock delay.
module draw_player #(
    parameter int          SPRITE_W  = 32,
    parameter int          SPRITE_H  = 32,
    parameter int          ADDR_BITS = 10,
    parameter logic [11:0] KEY_COLOR = 12'h0F0,
    parameter int          H_ACTIVE  = 1024,
    parameter int          V_ACTIVE  = 768
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 game_en,
    input  logic [10:0]          xpos,
    input  logic [10:0]          ypos,
    input  logic                 mirror,
    output logic [ADDR_BITS-1:0] rom_addr,
    input  logic [11:0]          rom_rgb,
    vga_if.snk                   in,
    vga_if.src                   out
);

    localparam int          COL_BITS = $clog2(SPRITE_W);
    localparam logic [10:0] X_MAX    = 11'(H_ACTIVE - SPRITE_W);
    localparam logic [10:0] Y_MAX    = 11'(V_ACTIVE - SPRITE_H);
    localparam logic [11:0] W_EXT    = 12'(SPRITE_W);
    localparam logic [11:0] H_EXT    = 12'(SPRITE_H);

    function automatic logic [10:0] clamp_pos(input logic [10:0] pos, input logic [10:0] lim);
        return (pos > lim) ? lim : pos;
    endfunction

    function automatic logic [11:0] select_rgb(input logic        blank,
                                               input logic        hit,
                                               input logic [11:0] sprite,
                                               input logic [11:0] menu);
        if (blank)
            return 12'h000;
        else if (hit && (sprite != KEY_COLOR))
            return sprite;
        else
            return menu;
    endfunction

    logic                 r_vblnk_d;
    logic [10:0]          r_x_l;
    logic [10:0]          r_y_l;
    logic                 r_mirror_l;

    logic [10:0]          r_hcount_p1, r_vcount_p1;
    logic                 r_hsync_p1, r_vsync_p1, r_hblnk_p1, r_vblnk_p1;
    logic [11:0]          r_rgb_p1;
    logic                 r_hit_p1;

    logic [10:0]          r_hcount_p2, r_vcount_p2;
    logic                 r_hsync_p2, r_vsync_p2, r_hblnk_p2, r_vblnk_p2;
    logic [11:0]          r_rgb_p2;
    logic                 r_hit_p2;

    logic [11:0]          w_x_end;
    logic [11:0]          w_y_end;
    logic                 w_inside;
    logic                 w_hit;
    logic [COL_BITS-1:0]  w_col_raw;
    logic [COL_BITS-1:0]  w_col;
    logic [10:0]          w_row;
    logic [ADDR_BITS-1:0] w_addr;

    // 12-bit ends keep x_l+SPRITE_W from wrapping near the clamp limits.
    assign w_x_end   = {1'b0, r_x_l} + W_EXT;
    assign w_y_end   = {1'b0, r_y_l} + H_EXT;
    assign w_inside  = (in.hcount >= r_x_l) && ({1'b0, in.hcount} < w_x_end) &&
                       (in.vcount >= r_y_l) && ({1'b0, in.vcount} < w_y_end);
    assign w_hit     = w_inside && game_en;
    assign w_col_raw = COL_BITS'(in.hcount - r_x_l);
    // With a power-of-two width, (SPRITE_W-1)-col is the bitwise complement of col.
    assign w_col     = r_mirror_l ? ~w_col_raw : w_col_raw;
    assign w_row     = in.vcount - r_y_l;
    assign w_addr    = ADDR_BITS'({w_row, w_col});

    // Position latch: reloaded only on the rising edge of vblank.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_vblnk_d  <= 1'b0;
            r_x_l      <= '0;
            r_y_l      <= '0;
            r_mirror_l <= 1'b0;
        end else begin
            r_vblnk_d <= in.vblnk;
            if (in.vblnk && !r_vblnk_d) begin
                r_x_l      <= clamp_pos(xpos, X_MAX);
                r_y_l      <= clamp_pos(ypos, Y_MAX);
                r_mirror_l <= mirror;
            end
        end
    end

    // Stage 1: register the stream and issue the ROM address.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hcount_p1 <= '0;
            r_vcount_p1 <= '0;
            r_hsync_p1  <= 1'b0;
            r_vsync_p1  <= 1'b0;
            r_hblnk_p1  <= 1'b0;
            r_vblnk_p1  <= 1'b0;
            r_rgb_p1    <= '0;
            r_hit_p1    <= 1'b0;
            rom_addr    <= '0;
        end else begin
            r_hcount_p1 <= in.hcount;
            r_vcount_p1 <= in.vcount;
            r_hsync_p1  <= in.hsync;
            r_vsync_p1  <= in.vsync;
            r_hblnk_p1  <= in.hblnk;
            r_vblnk_p1  <= in.vblnk;
            r_rgb_p1    <= in.rgb;
            r_hit_p1    <= w_hit;
            rom_addr    <= w_hit ? w_addr : '0;
        end
    end

    // Stage 2: wait out the ROM read latency.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_hcount_p2 <= '0;
            r_vcount_p2 <= '0;
            r_hsync_p2  <= 1'b0;
            r_vsync_p2  <= 1'b0;
            r_hblnk_p2  <= 1'b0;
            r_vblnk_p2  <= 1'b0;
            r_rgb_p2    <= '0;
            r_hit_p2    <= 1'b0;
        end else begin
            r_hcount_p2 <= r_hcount_p1;
            r_vcount_p2 <= r_vcount_p1;
            r_hsync_p2  <= r_hsync_p1;
            r_vsync_p2  <= r_vsync_p1;
            r_hblnk_p2  <= r_hblnk_p1;
            r_vblnk_p2  <= r_vblnk_p1;
            r_rgb_p2    <= r_rgb_p1;
            r_hit_p2    <= r_hit_p1;
        end
    end

    // Stage 3: merge the sprite pixel into the outgoing stream.
    always_ff @(posedge clk) begin
        if (!rst) begin
            out.hcount <= '0;
            out.vcount <= '0;
            out.hsync  <= 1'b0;
            out.vsync  <= 1'b0;
            out.hblnk  <= 1'b0;
            out.vblnk  <= 1'b0;
            out.rgb    <= '0;
        end else begin
            out.hcount <= r_hcount_p2;
            out.vcount <= r_vcount_p2;
            out.hsync  <= r_hsync_p2;
            out.vsync  <= r_vsync_p2;
            out.hblnk  <= r_hblnk_p2;
            out.vblnk  <= r_vblnk_p2;
            out.rgb    <= select_rgb(r_hblnk_p2 || r_vblnk_p2, r_hit_p2, rom_rgb, r_rgb_p2);
        end
    end

endmodule

// File: tb/tb_draw_player.sv
// Directed bench for draw_player: drives single pixels through the pipeline
// against a behavioural synchronous sprite ROM and checks hand-computed results.
module tb_draw_player;

    logic        clk = 1'b0;
    logic        rst;
    logic        game_en;
    logic [10:0] xpos;
    logic [10:0] ypos;
    logic        mirror;
    logic [9:0]  rom_addr;
    logic [11:0] rom_rgb;
    logic [11:0] rom [0:1023];

    int n_checks = 0;
    int n_fail   = 0;

    vga_if vin();
    vga_if vout();

    draw_player dut (
        .clk      (clk),
        .rst      (rst),
        .game_en  (game_en),
        .xpos     (xpos),
        .ypos     (ypos),
        .mirror   (mirror),
        .rom_addr (rom_addr),
        .rom_rgb  (rom_rgb),
        .in       (vin),
        .out      (vout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_rgb <= rom[rom_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fill_rom(input logic [11:0] val);
        for (int i = 0; i < 1024; i++) rom[i] = val;
    endtask

    task automatic vblank_pulse();
        vin.hblnk = 1'b1;
        vin.vblnk = 1'b1;
        step();
        vin.vblnk = 1'b0;
        vin.hblnk = 1'b0;
        step();
    endtask

    // Present one pixel, check the address one edge later and the output three edges later.
    task automatic probe(input string tag, input logic [10:0] h, input logic [10:0] v,
                         input logic hb, input logic [11:0] menu,
                         input logic [9:0] exp_addr, input logic [11:0] exp_rgb);
        vin.hcount = h;
        vin.vcount = v;
        vin.hsync  = h[0];
        vin.vsync  = v[0];
        vin.hblnk  = hb;
        vin.vblnk  = 1'b0;
        vin.rgb    = menu;
        step();
        check({tag, ".addr"}, 32'(rom_addr), 32'(exp_addr));
        step();
        step();
        check({tag, ".rgb"}, 32'(vout.rgb), 32'(exp_rgb));
        check({tag, ".hcount"}, 32'(vout.hcount), 32'(h));
        check({tag, ".hsync"}, 32'(vout.hsync), 32'(h[0]));
    endtask

    initial begin
        fill_rom(12'hF00);
        rst        = 1'b0;
        game_en    = 1'b1;
        xpos       = 11'd0;
        ypos       = 11'd0;
        mirror     = 1'b0;
        vin.hcount = 11'd5;
        vin.vcount = 11'd7;
        vin.hsync  = 1'b1;
        vin.vsync  = 1'b1;
        vin.hblnk  = 1'b0;
        vin.vblnk  = 1'b0;
        vin.rgb    = 12'hABC;
        step();
        step();
        step();
        check("reset.rgb",      32'(vout.rgb),    32'h0);
        check("reset.hcount",   32'(vout.hcount), 32'h0);
        check("reset.vcount",   32'(vout.vcount), 32'h0);
        check("reset.hsync",    32'(vout.hsync),  32'h0);
        check("reset.vsync",    32'(vout.vsync),  32'h0);
        check("reset.rom_addr", 32'(rom_addr),    32'h0);

        rst     = 1'b1;
        game_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            vin.hcount = 11'(500 + i);
            vin.vcount = 11'd300;
            step();
            if (i >= 2) check("latency.hcount", 32'(vout.hcount), 32'(500 + i - 2));
        end

        // Placement at (100,200)
        game_en = 1'b1;
        xpos    = 11'd100;
        ypos    = 11'd200;
        vblank_pulse();
        probe("place.tl",    11'd100, 11'd200, 1'b0, 12'h00F, 10'd0,    12'hF00);
        probe("place.br",    11'd131, 11'd231, 1'b0, 12'h00F, 10'd1023, 12'hF00);
        probe("place.in",    11'd101, 11'd201, 1'b0, 12'h00F, 10'd33,   12'hF00);
        probe("place.left",  11'd99,  11'd200, 1'b0, 12'h00F, 10'd0,    12'h00F);
        probe("place.right", 11'd132, 11'd200, 1'b0, 12'h00F, 10'd0,    12'h00F);
        probe("place.above", 11'd100, 11'd199, 1'b0, 12'h00F, 10'd0,    12'h00F);
        probe("place.below", 11'd100, 11'd232, 1'b0, 12'h00F, 10'd0,    12'h00F);

        // Transparency
        rom[5] = 12'h0F0;
        probe("key.pix5", 11'd105, 11'd200, 1'b0, 12'h00F, 10'd5, 12'h00F);
        probe("key.pix6", 11'd106, 11'd200, 1'b0, 12'h00F, 10'd6, 12'hF00);

        // Mirror: ignored until the next vblank rise
        for (int c = 0; c < 32; c++) rom[c] = 12'(c);
        mirror = 1'b1;
        probe("mirror.prelatch", 11'd100, 11'd200, 1'b0, 12'h00F, 10'd0, 12'h000);
        vblank_pulse();
        probe("mirror.left",  11'd100, 11'd200, 1'b0, 12'h00F, 10'd31, 12'h01F);
        probe("mirror.right", 11'd131, 11'd200, 1'b0, 12'h00F, 10'd0,  12'h000);
        probe("mirror.col3",  11'd103, 11'd200, 1'b0, 12'h00F, 10'd28, 12'h01C);

        // Clamp to (992,736) and latch hold
        fill_rom(12'hF00);
        mirror = 1'b0;
        xpos   = 11'd2000;
        ypos   = 11'd760;
        vblank_pulse();
        probe("clamp.tl",    11'd992,  11'd736, 1'b0, 12'h00F, 10'd0,    12'hF00);
        probe("clamp.br",    11'd1023, 11'd767, 1'b0, 12'h00F, 10'd1023, 12'hF00);
        probe("clamp.left",  11'd991,  11'd736, 1'b0, 12'h00F, 10'd0,    12'h00F);
        probe("clamp.hbeyond", 11'd1024, 11'd736, 1'b0, 12'h00F, 10'd0,  12'h00F);
        xpos = 11'd50;
        probe("latch.hold",  11'd993,  11'd736, 1'b0, 12'h00F, 10'd1,    12'hF00);
        probe("latch.nomove", 11'd51,  11'd736, 1'b0, 12'h00F, 10'd0,    12'h00F);
        vblank_pulse();
        probe("latch.moved", 11'd51,   11'd736, 1'b0, 12'h00F, 10'd1,    12'hF00);
        probe("latch.old",   11'd993,  11'd736, 1'b0, 12'h00F, 10'd0,    12'h00F);

        // Blanking and disable
        xpos = 11'd100;
        ypos = 11'd200;
        vblank_pulse();
        probe("blank.hit",   11'd100, 11'd200, 1'b1, 12'h00F, 10'd0,  12'h000);
        probe("blank.menu",  11'd50,  11'd200, 1'b1, 12'h00F, 10'd0,  12'h000);
        game_en = 1'b0;
        probe("disable.in",  11'd110, 11'd210, 1'b0, 12'h0A5, 10'd0,  12'h0A5);
        probe("disable.out", 11'd20,  11'd20,  1'b0, 12'h3C3, 10'd0,  12'h3C3);
        game_en = 1'b1;
        probe("enable.again", 11'd110, 11'd210, 1'b0, 12'h0A5, 10'd330, 12'hF00);

        // Mid-frame reset returns the latch to (0,0)
        rst = 1'b0;
        step();
        rst = 1'b1;
        probe("rst.origin", 11'd1,   11'd1,   1'b0, 12'h00F, 10'd33, 12'hF00);
        probe("rst.oldpos", 11'd100, 11'd200, 1'b0, 12'h00F, 10'd0,  12'h00F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
